decrypt_iter: RTL

//  Iterative, one-round-per-cycle decryptor for the team's 64-bit, 10-round nibble cipher.

---
 rtl/decrypt_iter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/decrypt_iter.sv
// ============================================================================
// Module      : decrypt_iter
// Description : Iterative one-round-per-cycle decryptor for the 64-bit,
//               10-round nibble cipher, valid/ready on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decrypt_iter #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_ROT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext,
  input  logic [63:0] secret_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext,
  output logic        busy,
  output logic [3:0]  round_idx
);

  localparam int       c_INIT_ROT = (KEY_ROT * NUM_ROUNDS) % 64;
  localparam int       c_STEP_ROT = (64 - (KEY_ROT % 64)) % 64;
  localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [63:0] r_stateReg;
  logic [63:0] r_rkReg;
  logic [63:0] r_keyReg;
  logic [63:0] r_plaintext;
  logic [3:0]  r_roundIdx;
  logic        r_outValid;
  logic        r_inReady;
  logic        r_busy;
  logic [63:0] w_roundOut;

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[(i + n) % 64] = x[i];
    return y;
  endfunction

  function automatic logic [3:0] invSBox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h2;  4'h1: r = 4'hE;  4'h2: r = 4'h9;  4'h3: r = 4'h5;
      4'h4: r = 4'h3;  4'h5: r = 4'hC;  4'h6: r = 4'h0;  4'h7: r = 4'hA;
      4'h8: r = 4'h7;  4'h9: r = 4'hF;  4'hA: r = 4'h8;  4'hB: r = 4'h1;
      4'hC: r = 4'hB;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  default: r = 4'h6;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] invShiftRows(input logic [63:0] x);
    return {x[51:48], x[63:52], x[39:32], x[47:40], x[27:16], x[31:28], x[15:0]};
  endfunction

  // Inverse round: undo AddRoundKey, then ShiftRows, then SBox.
  always_comb begin
    logic [63:0] w_shifted;
    w_shifted  = invShiftRows(r_stateReg ^ r_rkReg);
    w_roundOut = '0;
    for (int i = 0; i < 16; i++) w_roundOut[4*i +: 4] = invSBox(w_shifted[4*i +: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_stateReg  <= '0;
      r_rkReg     <= '0;
      r_keyReg    <= '0;
      r_plaintext <= '0;
      r_roundIdx  <= '0;
      r_outValid  <= 1'b0;
      r_inReady   <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_stateReg <= ciphertext;
            r_keyReg   <= secret_key;
            r_rkReg    <= rotl64(secret_key, c_INIT_ROT);
            r_roundIdx <= '0;
            r_inReady  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_stateReg <= w_roundOut;
          r_rkReg    <= rotl64(r_rkReg, c_STEP_ROT);
          r_roundIdx <= r_roundIdx + 4'd1;
          if (r_roundIdx == c_LAST_ROUND) begin
            // Final whitening with the original key recovers the plaintext.
            r_plaintext <= w_roundOut ^ r_keyReg;
            r_outValid  <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign plaintext = r_plaintext;
  assign busy      = r_busy;
  assign round_idx = r_roundIdx;

endmodule

`default_nettype wire
